dcache_axi_bridge: RTL and testbench
====================================

# dcache_axi_bridge

Single-outstanding bridge between the data cache's SRAM-like memory port (one 32-bit word per request) and an AXI4 master interface toward the memory system. It sits directly downstream of the data cache and converts each word read or write-back into one single-beat AXI read or write transaction. It returns read data and completion to the cache with a one-cycle `data_data_ok` pulse.

## Interface
- `A_WIDTH`, default 32: physical address width; `araddr` and `awaddr` carry `A_WIDTH` bits.
- `clk`  in  1  — the single clock.
- `resetn`  in  1  — synchronous reset, active low.
- `data_req`  in  1  — request from the cache, held high until `data_data_ok`.
- `data_wr`  in  1  — 1 = write, 0 = read.
- `data_wen`  in  4  — byte enables for a write.
- `data_addr`  in  32  — word address; bits [1:0] are ignored.
- `data_wdata`  in  32  — write data.
- `data_rdata`  out  32  — read data, valid while `data_data_ok` = 1.
- `data_addr_ok`  out  1  — request accepted this cycle.
- `data_data_ok`  out  1  — one-cycle completion pulse.
- `araddr`  out  A_WIDTH  — AXI read address, {addr[A_WIDTH-1:2], 2'b00}.
- `arvalid`  out  1  — AXI read-address valid.
- `arready`  in  1  — AXI read-address ready.
- `rdata`  in  32  — AXI read data.
- `rvalid`  in  1  — AXI read-data valid.
- `rready`  out  1  — AXI read-data ready.
- `awaddr`  out  A_WIDTH  — AXI write address, word aligned.
- `awvalid`  out  1  — AXI write-address valid.
- `awready`  in  1  — AXI write-address ready.
- `wdata`  out  32  — AXI write data.
- `wstrb`  out  4  — AXI write strobes, equal to the latched `data_wen`.
- `wvalid`  out  1  — AXI write-data valid.
- `wready`  in  1  — AXI write-data ready.
- `bvalid`  in  1  — AXI write-response valid; `bresp` is not consumed.
- `bready`  out  1  — AXI write-response ready.

Fixed AXI fields are tied off at the top level: id = 0, len = 0, size = 3'b010, burst = INCR, wlast = 1.

## Operation
- The state machine has six states: IDLE, AR, R, AWW, B, RESP.
- `data_addr_ok` = (state == IDLE) & `data_req`, combinational. On acceptance the block latches wr, addr, wdata and wen. All AXI outputs are driven only from these latched values.
- Read path: IDLE → AR. AR holds `arvalid` = 1 until `arready`, then → R. R holds `rready` = 1 until `rvalid`; `rdata` is captured into the `data_rdata` register, then → RESP.
- Write path: IDLE → AWW. AWW drives `awvalid` and `wvalid` together and keeps per-channel done flags.
  - Each valid drops in the cycle after its own handshake.
  - Handshakes may land on either channel first or on the same edge.
  - When both flags are set → B. B holds `bready` = 1 until `bvalid`, then → RESP.
- RESP: `data_data_ok` = 1 for exactly one cycle, then → IDLE. `data_addr_ok` is 0 in RESP. This prevents the cache's still-high `data_req` from being accepted twice.
- `data_rdata` holds its last captured value between reads. After a write its value is don't-care.
- Reset (`resetn` = 0 at a rising edge), in any state including mid-handshake, forces the following on the next edge:
  - state = IDLE;
  - `arvalid`, `awvalid`, `wvalid`, `rready`, `bready` = 0;
  - `data_data_ok` = 0;
  - `data_rdata` = 0;
  - done flags cleared.
- An outstanding AXI transaction is abandoned on reset; the slave shares the reset.

## Timing
- Minimum read latency: accept in cycle 0, `arvalid` in cycle 1 (with `arready` = 1), `rready` in cycle 2 (with `rvalid` = 1), `data_data_ok` in cycle 3.
- Minimum write latency: accept in cycle 0, AW and W in cycle 1, B in cycle 2, `data_data_ok` in cycle 3.
- Each extra cycle that `arready`, `rvalid`, `awready`, `wready` or `bvalid` is low adds exactly one cycle.
- Back-to-back: the earliest new acceptance is the cycle after RESP. A write-back followed by a refill reaches its second `data_data_ok` no sooner than 4 cycles after the first.
- All outputs are registered except `data_addr_ok`.
- Valids never drop before their handshake (AXI-compliant).

## Configuration
- `DCACHE_BRIDGE_POSTED_WR_EN` defined:
  - A write goes IDLE → RESP. `data_data_ok` pulses in cycle 1 after acceptance.
  - AWW and B then run in the background.
  - `data_addr_ok` stays 0 until `bvalid` & `bready` retires the write, so at most one transaction is outstanding.
  - Read behaviour is unchanged.
- Not defined: writes complete only after B, as described above.

## Test plan
- Read with AXI always ready, `data_addr` = 0x0000_1004, `rdata` = 0xDEAD_BEEF → `araddr` = 0x0000_1004; `data_data_ok` exactly 3 cycles after accept with `data_rdata` = 0xDEAD_BEEF; single pulse.
- Write 0x1234_5678, `wen` = 4'b0011, `addr` = 0x0000_2008; `awready` 2 cycles late, `wready` immediate → `wstrb` = 0011; `wvalid` drops after 1 cycle; B entered only after AW; `data_data_ok` 5 cycles after accept.
- Write-back then refill with `data_req` held across `data_data_ok` → exactly two acceptances; no duplicate AXI transaction.
- `rvalid` delayed 6 cycles → `rready` held high throughout; `data_data_ok` at cycle 9.
- `resetn` low while in AWW → next edge all valids 0, state IDLE; a new read is accepted afterwards normally.
- With `DCACHE_BRIDGE_POSTED_WR_EN`: write → `data_data_ok` at cycle 1; a following read gets `data_addr_ok` = 0 until `bvalid` arrives.

Source files
------------

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
//
// Converts single-word requests from the data cache's SRAM-like port into
// single-beat AXI4 transactions. Only one transaction is in flight at a time.
// Completion, and read data for reads, go back to the cache as a one-cycle
// data_data_ok pulse.
//
// Ports:
//   clk, resetn            clock; synchronous active-low reset
//   data_*                 cache side: req/wr/wen/addr/wdata in; rdata/addr_ok/data_ok out
//   ar*/r*                 AXI read address and read data channels
//   aw*/w*/b*              AXI write address, write data and write response channels
//   *id/*len/*size/*burst  fixed single-beat tie-offs (id 0, len 0, 4 bytes, INCR)
//
// Configuration macro:
//   DCACHE_BRIDGE_POSTED_WR_EN  acknowledge a write to the cache one cycle after
//                               acceptance and run AW/W/B afterwards. No new
//                               request is accepted until the B response arrives.
module dcache_axi_bridge #(
    parameter int unsigned A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               data_req,
    input  logic               data_wr,
    input  logic [3:0]         data_wen,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wdata,
    output logic [31:0]        data_rdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,

    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,

    input  logic [31:0]        rdata,
    input  logic               rvalid,
    output logic               rready,

    output logic [3:0]         awid,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,

    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,

    input  logic               bvalid,
    output logic               bready
);

`ifdef DCACHE_BRIDGE_POSTED_WR_EN
    localparam bit PostedWr = 1'b1;
`else
    localparam bit PostedWr = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAww,
        StB,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic               wr_q, wr_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wen_q, wen_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [31:0]        rdata_q, rdata_d;

    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic data_ok_q, data_ok_d;

    // Zero-extend the 32-bit cache address so any A_WIDTH can be sliced out.
    logic [A_WIDTH+31:0] addr_ext;
    assign addr_ext = {{A_WIDTH{1'b0}}, data_addr};

    // Accept only in IDLE; RESP is excluded so a still-high data_req is not taken twice.
    assign data_addr_ok = (state_q == StIdle) & data_req;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (data_req) begin
                    wr_d      = data_wr;
                    addr_d    = addr_ext[A_WIDTH-1:0];
                    wdata_d   = data_wdata;
                    wen_d     = data_wen;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (data_wr) begin
                        state_d = PostedWr ? StResp : StAww;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StAr: begin
                if (arvalid_q & arready) state_d = StR;
            end
            StR: begin
                if (rready_q & rvalid) begin
                    rdata_d = rdata;
                    state_d = StResp;
                end
            end
            StAww: begin
                if (awvalid_q & awready) aw_done_d = 1'b1;
                if (wvalid_q & wready)   w_done_d  = 1'b1;
                if (aw_done_d & w_done_d) state_d = StB;
            end
            StB: begin
                // A posted write was already acknowledged; retiring it just frees the port.
                if (bready_q & bvalid) state_d = PostedWr ? StIdle : StResp;
            end
            StResp: begin
                // With posted writes RESP is visited before the AXI write, not after.
                state_d = (PostedWr && wr_q) ? StAww : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered: derive them from the state being entered.
        arvalid_d = (state_d == StAr);
        rready_d  = (state_d == StR);
        awvalid_d = (state_d == StAww) & ~aw_done_d;
        wvalid_d  = (state_d == StAww) & ~w_done_d;
        bready_d  = (state_d == StB);
        data_ok_d = (state_d == StResp);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            data_ok_q <= data_ok_d;
        end
    end

    assign data_rdata   = rdata_q;
    assign data_data_ok = data_ok_q;

    assign araddr  = {addr_q[A_WIDTH-1:2], 2'b00};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = {addr_q[A_WIDTH-1:2], 2'b00};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

    assign arid    = 4'd0;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign awid    = 4'd0;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    // Address byte offset and zero-extension bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{addr_ext[A_WIDTH+31:A_WIDTH], addr_q[1:0]};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
module tb_dcache_axi_bridge;

`ifdef DCACHE_BRIDGE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req, data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    dcache_axi_bridge #(.A_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks   = 0;
    int failures = 0;
    int last_ok  = -1;

    // One cache request plus the slave's stall profile and the expected latency
    // (cycles from acceptance to data_data_ok).
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] rd;
        int          ar_d, r_d, aw_d, w_d, b_d;
        bit          b2b;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference latency from the protocol rules: 3 cycles minimum, plus every
    // stalled cycle; AW and W overlap, so only the slower one counts.
    function automatic int model_lat(input vec_t v);
        if (v.wr && POSTED) return 1;
        if (v.wr) return 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
        return 3 + v.ar_d + v.r_d;
    endfunction

    task automatic slave_quiet();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata   = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_req = 1'b0;
            slave_quiet();
            #1;
            chk("idle_ok", data_data_ok, 0);
            chk("idle_accept", data_addr_ok, 0);
            chk("idle_axi", {arvalid, rready, awvalid, wvalid, bready}, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; data_req = 1'b0; slave_quiet();
        @(negedge clk);
        resetn = 1'b1;
        last_ok = -1;
    endtask

    // Issues one request and plays a reactive AXI slave that stalls each
    // channel by the vector's delay. Stops early after cycle abort_at if >= 0.
    task automatic run_txn(input vec_t v, input int abort_at);
        logic [31:0] exp_addr;
        int  acc_c, ar_w, r_w, aw_w, w_w, b_w, n_ar, n_r, n_aw, n_w, n_b;
        bit  p_ar, p_r, p_aw, p_w, p_b, ok_seen, done;
        exp_addr = {v.addr[31:2], 2'b00};
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
        ok_seen = 0; done = 0;

        @(negedge clk);
        data_req = 1'b1; data_wr = v.wr; data_addr = v.addr;
        data_wdata = v.wdata; data_wen = v.wen;
        slave_quiet();
        #1;
        chk("accept", data_addr_ok, 1);
        chk("ok_pulse_end", data_data_ok, 0);
        acc_c = cyc_cnt;

        for (int c = 1; c <= 80 && !done; c++) begin
            @(negedge clk);
            // The cache keeps data_req high and changes its other fields; only
            // latched values may reach AXI.
            data_req = 1'b1; data_wr = $urandom_range(0, 1);
            data_addr = $urandom; data_wdata = $urandom; data_wen = $urandom;
            arready = arvalid && (ar_w >= v.ar_d);
            rvalid  = rready  && (r_w  >= v.r_d);
            rdata   = rvalid ? v.rd : $urandom;
            awready = awvalid && (aw_w >= v.aw_d);
            wready  = wvalid  && (w_w  >= v.w_d);
            bvalid  = bready  && (b_w  >= v.b_d);
            #1;
            chk("no_reaccept", data_addr_ok, 0);
            if (p_ar) chk("arvalid_hold", arvalid, 1);
            if (p_r)  chk("rready_hold", rready, 1);
            if (p_aw) chk("awvalid_hold", awvalid, 1);
            if (p_w)  chk("wvalid_hold", wvalid, 1);
            if (p_b)  chk("bready_hold", bready, 1);
            if (arvalid) chk("araddr", araddr, exp_addr);
            if (awvalid) chk("awaddr", awaddr, exp_addr);
            if (wvalid) begin
                chk("wdata", wdata, v.wdata);
                chk("wstrb", wstrb, v.wen);
            end
            if (bready) chk("b_after_aw_w", n_aw + n_w, 2);
            chk("wrong_channel", v.wr ? (arvalid | rready) : (awvalid | wvalid | bready), 0);

            if (ok_seen) begin
                chk("ok_single", data_data_ok, 0);
            end else if (data_data_ok) begin
                ok_seen = 1;
                chk("latency", cyc_cnt - acc_c, v.exp_lat);
                if (!v.wr) chk("rdata", data_rdata, v.rd);
                if (v.b2b && !POSTED && last_ok >= 0)
                    chk("b2b_gap", cyc_cnt - last_ok, v.exp_lat + 1);
                last_ok = cyc_cnt;
            end

            n_ar += int'(arvalid & arready);
            n_r  += int'(rready  & rvalid);
            n_aw += int'(awvalid & awready);
            n_w  += int'(wvalid  & wready);
            n_b  += int'(bready  & bvalid);
            p_ar = arvalid & ~arready; ar_w += int'(p_ar);
            p_r  = rready  & ~rvalid;  r_w  += int'(p_r);
            p_aw = awvalid & ~awready; aw_w += int'(p_aw);
            p_w  = wvalid  & ~wready;  w_w  += int'(p_w);
            p_b  = bready  & ~bvalid;  b_w  += int'(p_b);
            done = ok_seen && (!(POSTED && v.wr) || n_b == 1);
            if (c == abort_at) return;
        end

        chk("complete", done, 1);
        chk("n_ar", n_ar, v.wr ? 0 : 1);
        chk("n_r",  n_r,  v.wr ? 0 : 1);
        chk("n_aw", n_aw, v.wr ? 1 : 0);
        chk("n_w",  n_w,  v.wr ? 1 : 0);
        chk("n_b",  n_b,  v.wr ? 1 : 0);
        if (!done) do_reset();
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;

        tbl[0] = '{wr:0, addr:32'h0000_1004, wdata:0, wen:0, rd:32'hDEAD_BEEF,
                   ar_d:0, r_d:0, aw_d:0, w_d:0, b_d:0, b2b:0, exp_lat:3};
        tbl[1] = '{wr:1, addr:32'h0000_2008, wdata:32'h1234_5678, wen:4'b0011, rd:0,
                   ar_d:0, r_d:0, aw_d:2, w_d:0, b_d:0, b2b:0, exp_lat:(POSTED ? 1 : 5)};
        tbl[2] = '{wr:1, addr:32'h0000_3000, wdata:32'hA5A5_5A5A, wen:4'b1111, rd:0,
                   ar_d:0, r_d:0, aw_d:0, w_d:0, b_d:0, b2b:0, exp_lat:(POSTED ? 1 : 3)};
        tbl[3] = '{wr:0, addr:32'h0000_3000, wdata:0, wen:0, rd:32'hCAFE_F00D,
                   ar_d:0, r_d:0, aw_d:0, w_d:0, b_d:0, b2b:1, exp_lat:3};
        tbl[4] = '{wr:0, addr:32'h0000_1007, wdata:0, wen:0, rd:32'h0BAD_F00D,
                   ar_d:0, r_d:6, aw_d:0, w_d:0, b_d:0, b2b:0, exp_lat:9};
        tbl[5] = '{wr:1, addr:32'h0000_4010, wdata:32'h89AB_CDEF, wen:4'b1100, rd:0,
                   ar_d:0, r_d:0, aw_d:1, w_d:3, b_d:2, b2b:1, exp_lat:(POSTED ? 1 : 8)};
        tbl[6] = '{wr:0, addr:32'h0000_5000, wdata:0, wen:0, rd:32'h1357_9BDF,
                   ar_d:2, r_d:1, aw_d:0, w_d:0, b_d:0, b2b:1, exp_lat:6};

        resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wen = '0;
        data_addr = '0; data_wdata = '0;
        slave_quiet();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", {arvalid, rready, awvalid, wvalid, bready, data_data_ok}, 0);
        chk("rst_rdata", data_rdata, 0);
        chk("tie_ar", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
        chk("tie_aw", {awid, awlen, awsize, awburst, wlast}, {4'd0, 8'd0, 3'b010, 2'b01, 1'b1});
        @(negedge clk);
        resetn = 1'b1;
        idle(1);

        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].b2b) idle(2);
            run_txn(tbl[i], -1);
        end

        // Reset while the write address/data handshake is pending.
        idle(1);
        v = '{wr:1, addr:32'h0000_6000, wdata:32'h5555_AAAA, wen:4'b1111, rd:0,
              ar_d:0, r_d:0, aw_d:50, w_d:50, b_d:0, b2b:0, exp_lat:0};
        run_txn(v, 2);
        chk("pre_rst_awvalid", awvalid, 1);
        @(negedge clk);
        resetn = 1'b0; data_req = 1'b0; slave_quiet();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mid_rst_axi", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("mid_rst_ok", data_data_ok, 0);
        chk("mid_rst_rdata", data_rdata, 0);
        last_ok = -1;
        v = '{wr:0, addr:32'h0000_7008, wdata:0, wen:0, rd:32'h2468_ACE0,
              ar_d:1, r_d:0, aw_d:0, w_d:0, b_d:0, b2b:0, exp_lat:0};
        v.exp_lat = model_lat(v);
        run_txn(v, -1);

        for (int i = 0; i < 40; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.wen   = 4'($urandom_range(1, 15));
            v.rd    = $urandom;
            v.ar_d  = $urandom_range(0, 3);
            v.r_d   = $urandom_range(0, 3);
            v.aw_d  = $urandom_range(0, 3);
            v.w_d   = $urandom_range(0, 3);
            v.b_d   = $urandom_range(0, 3);
            v.b2b   = 1'($urandom_range(0, 1));
            v.exp_lat = model_lat(v);
            if (!v.b2b) idle($urandom_range(1, 2));
            run_txn(v, -1);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
